// File: rtl/mem_wb_ctrl.sv
// Memory-side miss controller: serialises cache fills and dirty
// evictions onto a single-port RAM through a one-deep write-back buffer.
module mem_wb_ctrl #(
  parameter int MEM_LAT = 2
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [7:0] req_tag,
  input  logic       req_wb,
  input  logic [7:0] req_wb_tag,
  input  logic [7:0] req_wb_data,
  output logic       resp_valid,
  output logic [7:0] resp_tag,
  output logic [7:0] resp_data,
  output logic [7:0] mem_address,
  output logic [7:0] mem_data,
  output logic       mem_wren,
  input  logic [7:0] mem_q,
  output logic       idle,
  output logic [7:0] rd_count,
  output logic [7:0] wb_count,
  output logic [7:0] fwd_count
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_ISSUE,
    S_RD_WAIT,
    S_RESP,
    S_WB_WRITE
  } state_t;

  localparam logic [3:0] LAT_M1 = 4'(MEM_LAT - 1);

  state_t     state_q, state_d;
  logic [3:0] wait_q, wait_d;
  logic [7:0] tag_q, tag_d;
  logic       wbuf_full_q, wbuf_full_d;
  logic [7:0] wbuf_tag_q, wbuf_tag_d;
  logic [7:0] wbuf_data_q, wbuf_data_d;
  logic       resp_valid_q, resp_valid_d;
  logic [7:0] resp_tag_q, resp_tag_d;
  logic [7:0] resp_data_q, resp_data_d;
  logic [7:0] mem_addr_q, mem_addr_d;
  logic [7:0] mem_data_q, mem_data_d;
  logic       mem_wren_q, mem_wren_d;
  logic       idle_q, idle_d;
  logic [7:0] rd_cnt_q, rd_cnt_d;
  logic [7:0] wb_cnt_q, wb_cnt_d;
  logic [7:0] fwd_cnt_q, fwd_cnt_d;
  logic       accept;

  // A full buffer cannot take a second victim until it drains.
  assign req_ready = (state_q == S_IDLE)
                   && !(wbuf_full_q && req_wb);
  assign accept    = req_valid && req_ready;

  always_comb begin
    state_d      = state_q;
    wait_d       = wait_q;
    tag_d        = tag_q;
    wbuf_full_d  = wbuf_full_q;
    wbuf_tag_d   = wbuf_tag_q;
    wbuf_data_d  = wbuf_data_q;
    resp_valid_d = 1'b0;
    resp_tag_d   = resp_tag_q;
    resp_data_d  = resp_data_q;
    mem_addr_d   = mem_addr_q;
    mem_data_d   = mem_data_q;
    mem_wren_d   = 1'b0;
    rd_cnt_d     = rd_cnt_q;
    wb_cnt_d     = wb_cnt_q;
    fwd_cnt_d    = fwd_cnt_q;

    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          tag_d = req_tag;
          if (req_wb) begin
            wbuf_full_d = 1'b1;
            wbuf_tag_d  = req_wb_tag;
            wbuf_data_d = req_wb_data;
          end
          if (wbuf_full_q && req_tag == wbuf_tag_q) begin
            state_d     = S_RESP;
            resp_data_d = wbuf_data_q;
            fwd_cnt_d   = fwd_cnt_q + 8'd1;
          end else if (req_wb && req_tag == req_wb_tag) begin
            state_d     = S_RESP;
            resp_data_d = req_wb_data;
            fwd_cnt_d   = fwd_cnt_q + 8'd1;
          end else begin
            state_d    = S_RD_ISSUE;
            mem_addr_d = req_tag;
            rd_cnt_d   = rd_cnt_q + 8'd1;
          end
        end else if (wbuf_full_q) begin
          state_d    = S_WB_WRITE;
          mem_addr_d = wbuf_tag_q;
          mem_data_d = wbuf_data_q;
          mem_wren_d = 1'b1;
        end
      end
      S_RD_ISSUE: begin
        state_d = S_RD_WAIT;
        wait_d  = LAT_M1;
      end
      S_RD_WAIT: begin
        if (wait_q == 4'd0) begin
          state_d     = S_RESP;
          resp_data_d = mem_q;
        end else begin
          wait_d = wait_q - 4'd1;
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      S_WB_WRITE: begin
        state_d     = S_IDLE;
        wbuf_full_d = 1'b0;
        wb_cnt_d    = wb_cnt_q + 8'd1;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (state_d == S_RESP) begin
      resp_valid_d = 1'b1;
      resp_tag_d   = tag_d;
    end
    idle_d = (state_d == S_IDLE) && !wbuf_full_d;
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q      <= S_IDLE;
      wait_q       <= 4'd0;
      tag_q        <= 8'd0;
      wbuf_full_q  <= 1'b0;
      wbuf_tag_q   <= 8'd0;
      wbuf_data_q  <= 8'd0;
      resp_valid_q <= 1'b0;
      resp_tag_q   <= 8'd0;
      resp_data_q  <= 8'd0;
      mem_addr_q   <= 8'd0;
      mem_data_q   <= 8'd0;
      mem_wren_q   <= 1'b0;
      idle_q       <= 1'b1;
      rd_cnt_q     <= 8'd0;
      wb_cnt_q     <= 8'd0;
      fwd_cnt_q    <= 8'd0;
    end else begin
      state_q      <= state_d;
      wait_q       <= wait_d;
      tag_q        <= tag_d;
      wbuf_full_q  <= wbuf_full_d;
      wbuf_tag_q   <= wbuf_tag_d;
      wbuf_data_q  <= wbuf_data_d;
      resp_valid_q <= resp_valid_d;
      resp_tag_q   <= resp_tag_d;
      resp_data_q  <= resp_data_d;
      mem_addr_q   <= mem_addr_d;
      mem_data_q   <= mem_data_d;
      mem_wren_q   <= mem_wren_d;
      idle_q       <= idle_d;
      rd_cnt_q     <= rd_cnt_d;
      wb_cnt_q     <= wb_cnt_d;
      fwd_cnt_q    <= fwd_cnt_d;
    end
  end

  assign resp_valid  = resp_valid_q;
  assign resp_tag    = resp_tag_q;
  assign resp_data   = resp_data_q;
  assign mem_address = mem_addr_q;
  assign mem_data    = mem_data_q;
  assign mem_wren    = mem_wren_q;
  assign idle        = idle_q;
  assign rd_count    = rd_cnt_q;
  assign wb_count    = wb_cnt_q;
  assign fwd_count   = fwd_cnt_q;

endmodule

// File: tb/tb_mem_wb_ctrl.sv
// Bench for mem_wb_ctrl: RAM model, request table and scoreboard
// of expected fills and write-backs.
module tb_mem_wb_ctrl;
  localparam int MEM_LAT = 2;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic       req_valid = 1'b0;
  logic       req_wb = 1'b0;
  logic [7:0] req_tag = 8'd0;
  logic [7:0] req_wb_tag = 8'd0;
  logic [7:0] req_wb_data = 8'd0;
  logic       req_ready, resp_valid, mem_wren, idle;
  logic [7:0] resp_tag, resp_data, mem_address, mem_data, mem_q;
  logic [7:0] rd_count, wb_count, fwd_count;

  mem_wb_ctrl #(.MEM_LAT(MEM_LAT)) dut (
    .clock(clock), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_tag(req_tag), .req_wb(req_wb),
    .req_wb_tag(req_wb_tag), .req_wb_data(req_wb_data),
    .resp_valid(resp_valid), .resp_tag(resp_tag),
    .resp_data(resp_data), .mem_address(mem_address),
    .mem_data(mem_data), .mem_wren(mem_wren), .mem_q(mem_q),
    .idle(idle), .rd_count(rd_count), .wb_count(wb_count),
    .fwd_count(fwd_count)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  function automatic logic [7:0] init_val(int i);
    case (i)
      3:  return 8'h7A;
      4:  return 8'h11;
      8:  return 8'h6F;
      11: return 8'h4E;
      12: return 8'h5D;
      default: return 8'(i * 37 + 5);
    endcase
  endfunction

  logic [7:0] mem [256];
  logic [7:0] pipe [MEM_LAT];
  bit mem_init = 1'b0;
  always @(posedge clock) begin
    if (!mem_init) begin
      for (int i = 0; i < 256; i++) mem[i] <= init_val(i);
      mem_init <= 1'b1;
    end else if (mem_wren) begin
      mem[mem_address] <= mem_data;
    end
    pipe[0] <= mem[mem_address];
    for (int i = 1; i < MEM_LAT; i++) pipe[i] <= pipe[i-1];
  end
  assign mem_q = pipe[MEM_LAT-1];

  int checks = 0;
  int errors = 0;

  task automatic chk8(input bit ok, input string name,
                      input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic chki(input bit ok, input string name,
                      input int act, input int exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  typedef struct {
    logic [7:0] tag;
    logic       wb;
    logic [7:0] wtag;
    logic [7:0] wdata;
    logic [7:0] exp_data;
    logic       fwd;
    logic       stall;
    logic       chain;
  } vec_t;

  typedef struct {
    logic [7:0] tag;
    logic [7:0] data;
    int         cyc;
  } rsp_t;

  typedef struct {
    logic [7:0] adr;
    logic [7:0] data;
    int         after;
  } wr_t;

  rsp_t rq[$];
  wr_t  wq[$];
  int   last_wr_cyc = -1;
  logic [7:0] last_wr_adr = 8'd0;

  always @(negedge clock) begin
    if (reset_n && resp_valid) begin
      if (rq.size() == 0) begin
        chk8(1'b0, "resp_unexpected", resp_tag, 8'h00);
      end else begin
        rsp_t e;
        e = rq.pop_front();
        chk8(resp_tag == e.tag, "resp_tag", resp_tag, e.tag);
        chk8(resp_data == e.data, "resp_data", resp_data, e.data);
        chki(cyc == e.cyc, "resp_cycle", cyc, e.cyc);
      end
    end
    if (reset_n && mem_wren) begin
      last_wr_cyc = cyc;
      last_wr_adr = mem_address;
      if (wq.size() == 0) begin
        chk8(1'b0, "write_unexpected", mem_address, 8'h00);
      end else begin
        wr_t w;
        w = wq.pop_front();
        chk8(mem_address == w.adr, "wr_addr", mem_address, w.adr);
        chk8(mem_data == w.data, "wr_data", mem_data, w.data);
        chki(cyc >= w.after, "wr_after_fill", cyc, w.after);
      end
    end
  end

  task automatic issue(input vec_t v, output int acc);
    bit got;
    got = 1'b0;
    acc = 0;
    @(posedge clock); #1;
    req_valid   = 1'b1;
    req_tag     = v.tag;
    req_wb      = v.wb;
    req_wb_tag  = v.wtag;
    req_wb_data = v.wdata;
    for (int n = 0; n < 40 && !got; n++) begin
      @(negedge clock);
      if (req_ready) begin
        rsp_t r;
        got   = 1'b1;
        acc   = cyc;
        r.tag = v.tag;
        r.data = v.exp_data;
        r.cyc = acc + (v.fwd ? 1 : MEM_LAT + 2);
        rq.push_back(r);
        if (v.wb) begin
          wr_t w;
          w.adr   = v.wtag;
          w.data  = v.wdata;
          w.after = r.cyc + 1;
          wq.push_back(w);
        end
      end else begin
        @(posedge clock); #1;
      end
    end
    if (got) begin
      @(posedge clock); #1;
    end else begin
      chk8(1'b0, "accept_timeout", v.tag, v.tag);
    end
    req_valid = 1'b0;
    req_wb    = 1'b0;
  endtask

  task automatic wait_drain();
    bit done;
    done = 1'b0;
    for (int n = 0; n < 60 && !done; n++) begin
      @(negedge clock);
      done = (rq.size() == 0) && (wq.size() == 0) && idle;
    end
    chki(done, "drain_timeout", rq.size() + wq.size(), 0);
  endtask

  vec_t vecs [7];
  int exp_rd = 0, exp_wb = 0, exp_fwd = 0;
  int acc;

  initial begin
    vec_t v;
    vecs[0] = '{8'h03, 1'b0, 8'h00, 8'h00, 8'h7A, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{8'h04, 1'b1, 8'h01, 8'h55, 8'h11, 1'b0, 1'b0, 1'b0};
    vecs[2] = '{8'h0A, 1'b1, 8'h0A, 8'h3C, 8'h3C, 1'b1, 1'b0, 1'b0};
    vecs[3] = '{8'h0B, 1'b1, 8'h02, 8'h99, 8'h4E, 1'b0, 1'b0, 1'b1};
    vecs[4] = '{8'h02, 1'b0, 8'h00, 8'h00, 8'h99, 1'b1, 1'b0, 1'b0};
    vecs[5] = '{8'h0C, 1'b1, 8'h06, 8'h10, 8'h5D, 1'b0, 1'b0, 1'b1};
    vecs[6] = '{8'h08, 1'b1, 8'h07, 8'h20, 8'h6F, 1'b0, 1'b1, 1'b0};

    repeat (3) @(posedge clock);
    #1 reset_n = 1'b1;
    @(negedge clock);
    chk8(8'(idle) == 8'd1, "rst_idle", 8'(idle), 8'd1);
    chk8(8'(req_ready) == 8'd1, "rst_ready", 8'(req_ready), 8'd1);
    chk8(8'(resp_valid) == 8'd0, "rst_resp_valid", 8'(resp_valid), 8'd0);
    chk8(resp_tag == 8'd0, "rst_resp_tag", resp_tag, 8'd0);
    chk8(resp_data == 8'd0, "rst_resp_data", resp_data, 8'd0);
    chk8(mem_address == 8'd0, "rst_mem_addr", mem_address, 8'd0);
    chk8(mem_data == 8'd0, "rst_mem_data", mem_data, 8'd0);
    chk8(8'(mem_wren) == 8'd0, "rst_mem_wren", 8'(mem_wren), 8'd0);
    chk8(rd_count == 8'd0, "rst_rd_count", rd_count, 8'd0);
    chk8(wb_count == 8'd0, "rst_wb_count", wb_count, 8'd0);
    chk8(fwd_count == 8'd0, "rst_fwd_count", fwd_count, 8'd0);

    for (int i = 0; i < 7; i++) begin
      issue(vecs[i], acc);
      if (vecs[i].fwd) exp_fwd++;
      else exp_rd++;
      if (vecs[i].wb) exp_wb++;
      if (vecs[i].stall)
        chki(last_wr_adr == 8'h06 && last_wr_cyc < acc,
             "stall_drain_first", last_wr_cyc, acc);
      if (!vecs[i].chain) begin
        wait_drain();
        chk8(rd_count == 8'(exp_rd), "rd_count", rd_count, 8'(exp_rd));
        chk8(wb_count == 8'(exp_wb), "wb_count", wb_count, 8'(exp_wb));
        chk8(fwd_count == 8'(exp_fwd), "fwd_count",
             fwd_count, 8'(exp_fwd));
      end
    end

    // Reset while a fill waits on memory and a victim is buffered.
    v = '{8'h09, 1'b1, 8'h05, 8'h22, 8'h00, 1'b0, 1'b0, 1'b0};
    issue(v, acc);
    @(posedge clock); #1;
    rq.delete();
    wq.delete();
    reset_n = 1'b0;
    @(posedge clock); #1;
    reset_n = 1'b1;
    @(negedge clock);
    chk8(8'(idle) == 8'd1, "rst2_idle", 8'(idle), 8'd1);
    chk8(8'(resp_valid) == 8'd0, "rst2_resp", 8'(resp_valid), 8'd0);
    chk8(8'(mem_wren) == 8'd0, "rst2_wren", 8'(mem_wren), 8'd0);
    chk8(rd_count == 8'd0, "rst2_rd_count", rd_count, 8'd0);
    repeat (8) @(negedge clock);
    chk8(8'(idle) == 8'd1, "rst2_idle_hold", 8'(idle), 8'd1);
    chk8(wb_count == 8'd0, "rst2_wb_count", wb_count, 8'd0);
    chk8(fwd_count == 8'd0, "rst2_fwd_count", fwd_count, 8'd0);
    exp_rd = 0;

    for (int i = 0; i < 256; i++) begin
      v = '{8'(i), 1'b0, 8'h00, 8'h00, mem[i], 1'b0, 1'b0, 1'b1};
      issue(v, acc);
      exp_rd++;
    end
    wait_drain();
    chk8(rd_count == 8'(exp_rd), "rd_wrap", rd_count, 8'(exp_rd));
    chk8(wb_count == 8'd0, "wrap_wb_count", wb_count, 8'd0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, errors %0d",
             errors);
    $fatal(1, "watchdog");
  end

endmodule
